mlp_layer_sequencer: RTL and testbench
======================================

MLP_LAYER_SEQUENCER -- requirements
Module: mlp_layer_sequencer

Interface
REQ-001 SHALL have parameter W1, default 4: input words per layer-1 neuron (1..256).
REQ-002 SHALL have parameter N1, default 8: layer-1 neurons (1..256).
REQ-003 SHALL have parameter W2, default 1: input words per layer-2 neuron (1..256).
REQ-004 SHALL have parameter N2, default 4: layer-2 neurons (1..256).
REQ-005 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: request to run one inference.
REQ-008 SHALL have port mem_valid, input, 1: current weight/activation word is available.
REQ-009 SHALL have port abort, input, 1: cancel request; used only under SEQ_ABORT_EN.
REQ-010 SHALL have port l1, output, 1: accumulator-mux select; 1 = layer-1 15-bit accumulator, 0 = layer-2 7-bit accumulator.
REQ-011 SHALL have port acc_clr, output, 1: clear the active accumulator.
REQ-012 SHALL have port acc_en, output, 1: accumulate the current word.
REQ-013 SHALL have port word_addr, output, 8: index of the word being consumed.
REQ-014 SHALL have port neuron_addr, output, 8: index of the neuron being computed.
REQ-015 SHALL have port wb, output, 1: write-back strobe for the neuron result.
REQ-016 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-017 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, CLR, ACC, WB and DONE, plus a registered layer flag.
REQ-019 SHALL register every output; no output SHALL be combinationally derived from an input.
REQ-020 IDLE: when start=1, SHALL set layer=1, neuron_addr=0 and word_addr=0, and go to CLR; otherwise SHALL stay in IDLE.
REQ-021 CLR: SHALL assert acc_clr for exactly one cycle, then go to ACC.
REQ-022 ACC: SHALL drive acc_en equal to mem_valid, cycle-aligned with word_addr.
REQ-023 ACC: SHALL increment word_addr on each mem_valid=1 and hold it while mem_valid=0 (stall).
REQ-024 ACC: when mem_valid=1 and word_addr equals the last word (W-1 for the current layer), SHALL go to WB and reset word_addr to 0.
REQ-025 WB: SHALL assert wb for one cycle with neuron_addr equal to the finished neuron.
REQ-026 Leaving WB on a layer-1 neuron other than the last: SHALL increment neuron_addr and go to CLR.
REQ-027 Leaving WB on the last layer-1 neuron (N1-1): SHALL clear the layer flag, set neuron_addr=0 and go to CLR.
REQ-028 Leaving WB on a layer-2 neuron: SHALL go to CLR for the next neuron, or to DONE after the last neuron (N2-1).
REQ-029 DONE: SHALL assert done for one cycle, then go to IDLE.
REQ-030 l1 SHALL equal the layer flag in CLR, ACC and WB, be 0 in DONE, and be 1 in IDLE.
REQ-031 start SHALL be ignored while busy=1.
REQ-032 With mem_valid held at 1, done SHALL rise exactly N1*(W1+2)+N2*(W2+2)+1 cycles after the cycle in which start is accepted (61 with the defaults).
REQ-033 acc_clr, acc_en and wb SHALL be mutually exclusive in every cycle.

Reset
REQ-034 On rst_n=0, asynchronously: state=IDLE, l1=1, acc_clr=0, acc_en=0, word_addr=0, neuron_addr=0, wb=0, busy=0, done=0.
REQ-035 Reset asserted mid-operation SHALL abandon the run with no wb and no done pulse; operation resumes only on a new start after release.

Configuration
REQ-036 Macro SEQ_ABORT_EN defined: abort=1 in any non-IDLE state SHALL force IDLE on the next edge with reset output values and no done pulse.
REQ-037 Macro SEQ_ABORT_EN defined: abort=1 coincident with start in IDLE SHALL take priority, so the start is not accepted.
REQ-038 Macro SEQ_ABORT_EN defined: abort in the same cycle as wb or done SHALL NOT suppress that strobe.
REQ-039 Macro SEQ_ABORT_EN undefined: the abort port SHALL be ignored and no abort logic synthesized.

Verification
REQ-040 Defaults, mem_valid=1, start pulse -> 8 wb with l1=1 and neuron_addr 0..7, then 4 wb with l1=0 and neuron_addr 0..3; done at cycle 61; busy high during cycles 1..61.
REQ-041 mem_valid low for 3 cycles mid-ACC at word_addr=2 -> word_addr held at 2 and acc_en=0 during the stall; done delayed by exactly 3 cycles.
REQ-042 start re-pulsed at cycle 20 -> ignored; exactly one done, at cycle 61.
REQ-043 rst_n=0 at cycle 30 -> all outputs at reset values immediately; a new start after release gives done 61 cycles later.
REQ-044 SEQ_ABORT_EN defined, abort at cycle 15 -> IDLE at cycle 16, no done; SEQ_ABORT_EN undefined, same stimulus -> done at cycle 61.
REQ-045 W1=1, N1=1, W2=1, N2=1 -> sequence CLR, ACC, WB, CLR, ACC, WB, DONE; done at cycle 7.

Source files
------------

// File: rtl/mlp_layer_sequencer.sv
// Two-layer MLP inference sequencer: walks neurons and words, strobing clear/accumulate/write-back.
// Optional SEQ_ABORT_EN adds an abort input that returns the sequencer to IDLE from any busy state.
module mlp_layer_sequencer #(
    parameter int W1 = 4,
    parameter int N1 = 8,
    parameter int W2 = 1,
    parameter int N2 = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mem_valid,
    input  logic       abort,
    output logic       l1,
    output logic       acc_clr,
    output logic       acc_en,
    output logic [7:0] word_addr,
    output logic [7:0] neuron_addr,
    output logic       wb,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, CLR, ACC, WB, DONE} state_t;

    localparam logic [7:0] W1_LAST = 8'(W1 - 1);
    localparam logic [7:0] N1_LAST = 8'(N1 - 1);
    localparam logic [7:0] W2_LAST = 8'(W2 - 1);
    localparam logic [7:0] N2_LAST = 8'(N2 - 1);

    state_t     state, state_nx;
    logic       layer;
    logic [7:0] word_q;
    logic [7:0] neuron_q;
    logic       acc_en_q;
    logic       kill;
    logic       start_ok;
    logic       word_end;
    logic       last_l1_neuron;
    logic       last_l2_neuron;

`ifdef SEQ_ABORT_EN
    assign kill     = abort && (state != IDLE);
    assign start_ok = start && !abort;
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign kill         = 1'b0;
    assign start_ok     = start;
`endif

    // acc_en_q is the registered form of mem_valid, so a word counts as consumed when acc_en_q is high
    assign word_end       = acc_en_q && (word_q == (layer ? W1_LAST : W2_LAST));
    assign last_l1_neuron = (neuron_q == N1_LAST);
    assign last_l2_neuron = (neuron_q == N2_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = CLR;
            CLR:     state_nx = ACC;
            ACC:     if (word_end) state_nx = WB;
            WB:      state_nx = (!layer && last_l2_neuron) ? DONE : CLR;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (kill) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer    <= 1'b1;
            word_q   <= 8'd0;
            neuron_q <= 8'd0;
            acc_en_q <= 1'b0;
        end else if (kill) begin
            layer    <= 1'b1;
            word_q   <= 8'd0;
            neuron_q <= 8'd0;
            acc_en_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    acc_en_q <= 1'b0;
                    if (start_ok) begin
                        layer    <= 1'b1;
                        word_q   <= 8'd0;
                        neuron_q <= 8'd0;
                    end
                end
                CLR: acc_en_q <= mem_valid;
                ACC: begin
                    if (word_end) begin
                        word_q   <= 8'd0;
                        acc_en_q <= 1'b0;
                    end else begin
                        if (acc_en_q) word_q <= word_q + 8'd1;
                        acc_en_q <= mem_valid;
                    end
                end
                WB: begin
                    acc_en_q <= 1'b0;
                    if (layer) begin
                        if (last_l1_neuron) begin
                            layer    <= 1'b0;
                            neuron_q <= 8'd0;
                        end else begin
                            neuron_q <= neuron_q + 8'd1;
                        end
                    end else if (!last_l2_neuron) begin
                        neuron_q <= neuron_q + 8'd1;
                    end
                end
                DONE: begin
                    acc_en_q <= 1'b0;
                    layer    <= 1'b1;
                    neuron_q <= 8'd0;
                end
                default: acc_en_q <= 1'b0;
            endcase
        end
    end

    // Outputs decode only registered state, never a live input
    always_comb begin
        l1          = layer;
        acc_clr     = 1'b0;
        acc_en      = acc_en_q;
        word_addr   = word_q;
        neuron_addr = neuron_q;
        wb          = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            IDLE: begin
                l1   = 1'b1;
                busy = 1'b0;
            end
            CLR:  acc_clr = 1'b1;
            WB:   wb = 1'b1;
            DONE: begin
                l1   = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed self-checking bench for mlp_layer_sequencer (default and minimal parameter sets).
module tb_mlp_layer_sequencer;

`ifdef SEQ_ABORT_EN
    localparam bit ABORT_ON = 1'b1;
`else
    localparam bit ABORT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, start_s, mem_valid, abort;
    logic       l1, acc_clr, acc_en, wb, busy, done;
    logic [7:0] word_addr, neuron_addr;
    logic       s_l1, s_acc_clr, s_acc_en, s_wb, s_busy, s_done;
    logic [7:0] s_word_addr, s_neuron_addr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mlp_layer_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_valid(mem_valid), .abort(abort),
        .l1(l1), .acc_clr(acc_clr), .acc_en(acc_en), .word_addr(word_addr),
        .neuron_addr(neuron_addr), .wb(wb), .busy(busy), .done(done)
    );

    mlp_layer_sequencer #(.W1(1), .N1(1), .W2(1), .N2(1)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_s), .mem_valid(mem_valid), .abort(abort),
        .l1(s_l1), .acc_clr(s_acc_clr), .acc_en(s_acc_en), .word_addr(s_word_addr),
        .neuron_addr(s_neuron_addr), .wb(s_wb), .busy(s_busy), .done(s_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        chk("exclusive", 32'((acc_clr & acc_en) | (acc_clr & wb) | (acc_en & wb)), 32'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_l1"}, 32'(l1), 32'd1);
        chk({tag, "_acc_clr"}, 32'(acc_clr), 32'd0);
        chk({tag, "_acc_en"}, 32'(acc_en), 32'd0);
        chk({tag, "_wb"}, 32'(wb), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_word"}, 32'(word_addr), 32'd0);
        chk({tag, "_neuron"}, 32'(neuron_addr), 32'd0);
    endtask

    // Runs one inference from cycle 1 (start accepted in cycle 0) and checks the strobe timeline.
    task automatic run(input int stall_s, input int restart_at, input int abort_at);
        int extra, dn, busy_end, wbk, dcount, exp_wb;
        bit ab;
        extra    = (stall_s > 0) ? 3 : 0;
        ab       = ABORT_ON && (abort_at > 0);
        dn       = 61 + extra;
        busy_end = ab ? abort_at : dn;
        wbk      = 0;
        dcount   = 0;
        while (cyc <= 67) begin
            mem_valid = !(stall_s > 0 && cyc >= stall_s && cyc < stall_s + 3);
            start     = (cyc == restart_at);
            abort     = (cyc == abort_at);
            chk("busy", 32'(busy), 32'(cyc <= busy_end));
            if (cyc == 1) chk("first_clr", 32'(acc_clr), 32'd1);
            if (stall_s == 0 && cyc == 5) begin
                chk("last_word_addr", 32'(word_addr), 32'd3);
                chk("last_word_en", 32'(acc_en), 32'd1);
            end
            if (stall_s > 0 && cyc > stall_s && cyc <= stall_s + 3) begin
                chk("stall_addr", 32'(word_addr), 32'd2);
                chk("stall_en", 32'(acc_en), 32'd0);
            end
            if (wb) begin
                exp_wb = (wbk < 8) ? 6 + 6 * wbk : 51 + 3 * (wbk - 8);
                chk("wb_cycle", cyc, exp_wb + extra);
                chk("wb_l1", 32'(l1), 32'(wbk < 8));
                chk("wb_neuron", 32'(neuron_addr), (wbk < 8) ? wbk : wbk - 8);
                wbk++;
            end
            if (done) begin
                dcount++;
                chk("done_cycle", cyc, dn);
                chk("done_l1", 32'(l1), 32'd0);
            end
            if (ab && cyc == abort_at + 1) check_idle_outputs("abort_idle");
            tick();
        end
        start     = 1'b0;
        abort     = 1'b0;
        mem_valid = 1'b1;
        chk("wb_count", wbk, ab ? 2 : 12);
        chk("done_count", dcount, ab ? 0 : 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        start_s   = 1'b0;
        mem_valid = 1'b1;
        abort     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_no_start", 32'(busy), 32'd0);

        // Full run, mem_valid always high
        do_start();
        run(0, 0, 0);

        // Three-cycle memory stall while word 2 is pending
        do_start();
        run(3, 0, 0);

        // Start re-pulsed while busy
        do_start();
        run(0, 20, 0);

        // Reset mid-run, then a fresh run
        do_start();
        while (cyc < 30) tick();
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrun_reset");
        tick();
        tick();
        chk("reset_hold_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("after_release_busy", 32'(busy), 32'd0);
        chk("after_release_done", 32'(done), 32'd0);
        do_start();
        run(0, 0, 0);

        // Abort at cycle 15 (honoured only when the abort feature is built in)
        do_start();
        run(0, 0, 15);

`ifdef SEQ_ABORT_EN
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_beats_start", 32'(busy), 32'd0);
        tick();
        chk("abort_beats_start2", 32'(busy), 32'd0);
`endif

        // Minimal configuration: CLR ACC WB CLR ACC WB DONE
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            logic [3:0] exp_code;
            logic       exp_l1;
            case (c)
                1: begin exp_code = 4'b1000; exp_l1 = 1'b1; end
                2: begin exp_code = 4'b0100; exp_l1 = 1'b1; end
                3: begin exp_code = 4'b0010; exp_l1 = 1'b1; end
                4: begin exp_code = 4'b1000; exp_l1 = 1'b0; end
                5: begin exp_code = 4'b0100; exp_l1 = 1'b0; end
                6: begin exp_code = 4'b0010; exp_l1 = 1'b0; end
                7: begin exp_code = 4'b0001; exp_l1 = 1'b0; end
                default: begin exp_code = 4'b0000; exp_l1 = 1'b1; end
            endcase
            chk("small_strobes", 32'({s_acc_clr, s_acc_en, s_wb, s_done}), 32'(exp_code));
            chk("small_l1", 32'(s_l1), 32'(exp_l1));
            chk("small_busy", 32'(s_busy), 32'(c <= 7));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
